// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the operand-packing datapath controller:
// state encoding, default timeout and datapath widths.
package dp_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      LOAD   = 3'd2,
      WAIT   = 3'd3,
      RESULT = 3'd4,
      ERR    = 3'd5
   } state_t;

   localparam int unsigned DEF_TIMEOUT = 15;
   localparam int unsigned OPD_W       = 4;
   localparam int unsigned RES_W       = 8;

endpackage

// File: rtl/dp_timeout_cnt.sv
// Cycle counter for the WAIT state; expired flags the last permitted cycle.
module dp_timeout_cnt
   import dp_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT,
   parameter int unsigned TO_W    = 4
) (
   input  logic            clk,
   input  logic            clr_n,
   input  logic            clear,
   input  logic            inc,
   output logic [TO_W-1:0] count,
   output logic            expired
);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc)
         count <= count + TO_W'(1);
   end

   assign expired = (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/dp_controller.sv
// Host-facing sequencer for the operand-packing datapath: accept operands,
// pulse clear then load, wait for done (with timeout), present the result.
module dp_controller
   import dp_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT,
   parameter int unsigned TO_W    = 4,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             start,
   input  logic [3:0]       a_in,
   input  logic [3:0]       b_in,
   output logic             ready,
   output logic [7:0]       result,
   output logic             result_valid,
   input  logic             result_ack,
   output logic             timeout_err,
   output logic [CNT_W-1:0] op_count,
   output logic             dp_clr,
   output logic             dp_en,
   output logic [3:0]       dp_a,
   output logic [3:0]       dp_b,
   input  logic             dp_done,
   input  logic [7:0]       dp_out
);

   state_t            state;
   logic [TO_W-1:0]   to_count;
   logic              to_expired;

   // LOAD is the only predecessor of WAIT, so clearing there restarts the count on every entry.
   dp_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timeout (
      .clk     (clk),
      .clr_n   (clr_n),
      .clear   (state == LOAD),
      .inc     (state == WAIT),
      .count   (to_count),
      .expired (to_expired)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state       <= IDLE;
         result      <= '0;
         op_count    <= '0;
         dp_a        <= '0;
         dp_b        <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               dp_a        <= a_in;
               dp_b        <= b_in;
               timeout_err <= 1'b0;
               state       <= CLEAR;
            end
            CLEAR: state <= LOAD;
            LOAD:  state <= WAIT;
            // done wins over expiry on the final permitted cycle
            WAIT: if (dp_done) begin
               result   <= dp_out;
               op_count <= op_count + CNT_W'(1);
               state    <= RESULT;
            end else if (to_expired) begin
               state <= ERR;
            end
            RESULT: if (result_ack) state <= IDLE;
            ERR: begin
               timeout_err <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ready        = (state == IDLE);
   assign dp_clr       = (state == CLEAR);
   assign dp_en        = (state == LOAD);
   assign result_valid = (state == RESULT);

   a_wait_bound: assert property (@(posedge clk) disable iff (!clr_n)
      (state == WAIT) |-> (to_count <= TO_W'(TIMEOUT - 1)));

endmodule

// File: tb/tb_dp_controller.sv
// Bench for dp_controller: behavioural datapath with programmable done delay,
// directed stimulus pushing expectations into a scoreboard checked by a monitor.
module tb_dp_controller;

   localparam int NEVER = 1000;

   logic       clk = 1'b0;
   logic       clr_n, start, result_ack;
   logic [3:0] a_in, b_in, dp_a, dp_b;
   logic       ready, result_valid, timeout_err, dp_clr, dp_en, dp_done;
   logic [7:0] result, op_count, dp_out;

   int tests = 0;
   int errors = 0;
   int dly = 0;

   typedef struct {
      bit         err;
      logic [7:0] res;
      logic [7:0] cnt;
   } exp_t;
   exp_t q[$];
   logic [7:0] exp_count = '0;
   logic [7:0] last_good = '0;

   always #5 clk = ~clk;

   dp_controller #(.TIMEOUT(15), .TO_W(4), .CNT_W(8)) dut (
      .clk          (clk),
      .clr_n        (clr_n),
      .start        (start),
      .a_in         (a_in),
      .b_in         (b_in),
      .ready        (ready),
      .result       (result),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .timeout_err  (timeout_err),
      .op_count     (op_count),
      .dp_clr       (dp_clr),
      .dp_en        (dp_en),
      .dp_a         (dp_a),
      .dp_b         (dp_b),
      .dp_done      (dp_done),
      .dp_out       (dp_out)
   );

   // Datapath model: done rises dly cycles after the load edge.
   logic armed;
   int   dcnt;
   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         dp_out <= '0; armed <= 1'b0; dcnt <= 0;
      end else if (dp_clr) begin
         dp_out <= '0; armed <= 1'b0;
      end else if (dp_en) begin
         dp_out <= {dp_a, dp_b}; armed <= 1'b1; dcnt <= dly;
      end else if (armed && dcnt > 0) begin
         dcnt <= dcnt - 1;
      end
   end
   assign dp_done = armed && (dcnt == 0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: each rising result_valid or timeout_err consumes one expectation.
   logic rv_q = 1'b0, te_q = 1'b0;
   always @(negedge clk) begin
      if (clr_n) begin
         if ((result_valid && !rv_q) || (timeout_err && !te_q)) begin
            if (q.size() == 0) begin
               chk("sb_unexpected_event", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("sb_kind_err", {31'd0, timeout_err}, {31'd0, e.err});
               chk("sb_kind_valid", {31'd0, result_valid}, {31'd0, !e.err});
               chk("sb_result", {24'd0, result}, {24'd0, e.res});
               chk("sb_op_count", {24'd0, op_count}, {24'd0, e.cnt});
            end
         end
      end
      rv_q = result_valid;
      te_q = timeout_err;
   end

   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int d,
                         input int ack_wait, input bit exp_err, output int n);
      int w;
      dly = d;
      w = 0;
      while (!ready && w < 50) begin @(posedge clk); #1; w++; end
      if (!ready) chk("ready_timeout", 32'd0, 32'd1);
      if (exp_err) begin
         q.push_back('{err: 1'b1, res: last_good, cnt: exp_count});
      end else begin
         exp_count++;
         last_good = {a, b};
         q.push_back('{err: 1'b0, res: {a, b}, cnt: exp_count});
      end
      a_in = a; b_in = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("accept_clears_err", {31'd0, timeout_err}, 32'd0);
      chk("accept_dp_ab", {24'd0, dp_a, dp_b}, {24'd0, a, b});
      n = 0;
      while (!(result_valid || timeout_err) && n < 40) begin @(posedge clk); #1; n++; end
      if (n >= 40) chk("completion_timeout", 32'd0, 32'd1);
      if (result_valid) begin
         repeat (ack_wait) begin @(posedge clk); #1; end
         result_ack = 1'b1;
         @(posedge clk); #1;
         result_ack = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      clr_n = 1'b0; start = 1'b0; result_ack = 1'b0; a_in = '0; b_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_valid", {31'd0, result_valid}, 32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_count", {24'd0, op_count}, 32'd0);
      chk("rst_err", {31'd0, timeout_err}, 32'd0);
      chk("rst_dp", {24'd0, dp_a, dp_b}, 32'd0);
      chk("rst_strobes", {30'd0, dp_clr, dp_en}, 32'd0);
      clr_n = 1'b1;
      @(posedge clk); #1;

      // First op with cycle-exact sequencing checks
      exp_count = 8'd1; last_good = 8'hA5;
      q.push_back('{err: 1'b0, res: 8'hA5, cnt: 8'd1});
      a_in = 4'hA; b_in = 4'h5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("t1_clr_pulse", {30'd0, dp_clr, dp_en}, 32'd2);
      chk("t1_ready_low", {31'd0, ready}, 32'd0);
      chk("t1_dp_ab", {24'd0, dp_a, dp_b}, 32'hA5);
      @(posedge clk); #1;
      chk("t1_en_pulse", {30'd0, dp_clr, dp_en}, 32'd1);
      @(posedge clk); #1;
      chk("t1_wait_strobes", {30'd0, dp_clr, dp_en}, 32'd0);
      chk("t1_not_yet_valid", {31'd0, result_valid}, 32'd0);
      @(posedge clk); #1;
      chk("t1_valid_at_n3", {31'd0, result_valid}, 32'd1);
      chk("t1_result", {24'd0, result}, 32'hA5);
      chk("t1_count", {24'd0, op_count}, 32'd1);

      // Hold without ack; start pulses must be ignored
      for (int k = 0; k < 10; k++) begin
         start = (k % 2 == 0); a_in = 4'hF; b_in = 4'hF;
         @(posedge clk); #1;
         chk("hold_result", {24'd0, result}, 32'hA5);
         chk("hold_ready", {31'd0, ready}, 32'd0);
         chk("hold_valid", {31'd0, result_valid}, 32'd1);
      end
      start = 1'b1; result_ack = 1'b1; a_in = 4'h7; b_in = 4'h7;
      @(posedge clk); #1;
      start = 1'b0; result_ack = 1'b0;
      chk("ack_ready", {31'd0, ready}, 32'd1);
      chk("ack_start_ignored", {24'd0, dp_a, dp_b}, 32'hA5);
      chk("ack_count", {24'd0, op_count}, 32'd1);
      @(posedge clk); #1;
      chk("idle_stays", {31'd0, ready}, 32'd1);

      // Timeout with done never arriving, then recovery
      run_op(4'h7, 4'h7, NEVER, 0, 1'b1, n);
      chk("to_latency", n, 32'd18);
      chk("to_ready", {31'd0, ready}, 32'd1);
      chk("to_result_kept", {24'd0, result}, 32'hA5);
      repeat (2) @(posedge clk); #1;
      chk("to_sticky", {31'd0, timeout_err}, 32'd1);
      run_op(4'h3, 4'hC, 0, 0, 1'b0, n);
      chk("rec_latency", n, 32'd3);
      chk("rec_err_clear", {31'd0, timeout_err}, 32'd0);

      // done exactly on the last permitted WAIT cycle, then one cycle too late
      run_op(4'h6, 4'h9, 14, 0, 1'b0, n);
      chk("edge14_latency", n, 32'd17);
      chk("edge14_no_err", {31'd0, timeout_err}, 32'd0);
      run_op(4'h2, 4'h4, 15, 0, 1'b1, n);
      chk("edge15_latency", n, 32'd18);

      // Reset while in WAIT
      dly = NEVER; a_in = 4'h9; b_in = 4'h9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      clr_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, result_valid}, 32'd0);
      chk("mid_rst_result", {24'd0, result}, 32'd0);
      chk("mid_rst_count", {24'd0, op_count}, 32'd0);
      chk("mid_rst_err", {31'd0, timeout_err}, 32'd0);
      chk("mid_rst_dp", {24'd0, dp_a, dp_b}, 32'd0);
      chk("mid_rst_strobes", {30'd0, dp_clr, dp_en}, 32'd0);
      exp_count = '0; last_good = '0;
      @(posedge clk); #1;
      clr_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", {31'd0, ready}, 32'd1);
      chk("post_rst_count", {24'd0, op_count}, 32'd0);

      // 256 back-to-back ops with immediate ack; op_count wraps to 0
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = i[7:0];
         run_op(v[7:4], v[3:0], 0, 0, 1'b0, n);
         chk("b2b_latency", n, 32'd3);
      end
      chk("wrap_count", {24'd0, op_count}, 32'd0);

      repeat (3) @(posedge clk); #1;
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/dp_controller.md
Name: dp_controller

Overview:
- Control stage directly upstream of the 8-bit operand-packing datapath.
- Accepts one operand pair from the host with a start/ready handshake, then sequences the datapath: clear, then load.
- Waits for the datapath's done flag, captures the packed 8-bit result and presents it with a valid/ack handshake.
- Flags a timeout if done never arrives; counts completed operations.

Parameters:
- TIMEOUT, 15: maximum number of cycles in WAIT without dp_done before aborting.
- TO_W, 4: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.
- CNT_W, 8: width of op_count.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  host request; accepted only when ready=1.
- a_in  in  4  host operand A; sampled at acceptance.
- b_in  in  4  host operand B; sampled at acceptance.
- ready  out  1  high only in IDLE.
- result  out  8  captured datapath output.
- result_valid  out  1  result available; held until acknowledged.
- result_ack  in  1  host consumes result.
- timeout_err  out  1  sticky error flag; cleared on the next accepted start.
- op_count  out  CNT_W  number of successful captures; wraps.
- dp_clr  out  1  datapath clear, active high.
- dp_en  out  1  datapath load enable.
- dp_a  out  4  registered operand A to datapath.
- dp_b  out  4  registered operand B to datapath.
- dp_done  in  1  datapath done; registered in the datapath.
- dp_out  in  8  datapath packed output.

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE; result, op_count, dp_a, dp_b and the timeout counter = 0; result_valid=0, timeout_err=0. dp_en and dp_clr are decoded from state, so both are 0.
- Reset asserted mid-operation aborts immediately. Any captured result is discarded.
- States: IDLE, CLEAR, LOAD, WAIT, RESULT, ERR.
- IDLE: ready=1. On start=1, register a_in/b_in into dp_a/dp_b, clear timeout_err, then go to CLEAR.
- CLEAR: dp_clr=1 for exactly one cycle, then LOAD.
- LOAD: dp_en=1 for exactly one cycle, then WAIT. The datapath registers {A,B} and done=1 on this edge.
- WAIT: dp_en=0 and dp_clr=0; the timeout counter increments each cycle.
  - If dp_done=1: result<=dp_out, op_count<=op_count+1 (mod 2^CNT_W), go to RESULT.
  - Else if counter==TIMEOUT-1: go to ERR.
  - dp_done=1 on the final timeout cycle counts as success (done has priority).
- RESULT: result_valid=1. On result_ack=1, go to IDLE. Without ack, stay indefinitely; result is held stable.
- ERR: timeout_err<=1, one cycle, then IDLE. result and op_count are unchanged.
- The timeout counter is cleared on every entry to WAIT.
- Latency: start accepted at edge N → result_valid=1 after edge N+3 with a well-behaved datapath. Minimum repeat interval is 5 cycles (ack in the first valid cycle).
- dp_a/dp_b remain stable from acceptance until the next acceptance.
- start while ready=0 is ignored (not queued). start and result_ack in the same cycle in RESULT: ack is honoured, start is ignored.
- result_ack outside RESULT has no effect.
- op_count at 255 plus one success → 0, with no flag.
- dp_out is sampled only in WAIT when dp_done=1; dp_done outside WAIT is ignored.

Decomposition:
- Shared package dp_ctrl_pkg holds:
  - the state encoding (3-bit localparams IDLE=0 … ERR=5);
  - the default TIMEOUT;
  - the datapath operand width (4) and result width (8).
- One natural sub-module: dp_timeout_cnt.
  - Ports: clk, clr_n, clear, inc; outputs count and expired.
  - Asserts expired at count==TIMEOUT-1.

Test Plan:
- Reset then start with a_in=4'hA, b_in=4'h5, connected to the real datapath → dp_clr pulses 1 cycle, then dp_en 1 cycle; result_valid rises 3 edges after acceptance with result=8'hA5; op_count=1.
- Hold result_ack=0 for 10 cycles, then pulse it → result stays 8'hA5 and ready stays 0 throughout; start pulses during the hold are ignored; ready=1 the cycle after ack.
- Stub the datapath with dp_done tied 0 → after TIMEOUT (15) cycles in WAIT, timeout_err=1 and state returns to IDLE; the next start (3,C) clears timeout_err and, with dp_done restored, gives result=8'h3C.
- Run 256 back-to-back operations (a=i[7:4], b=i[3:0]) with immediate ack → each result equals the operand pair; op_count wraps to 0 after the 256th.
- Assert clr_n=0 while in WAIT (dp_done stub delayed) → all outputs are 0 immediately, no result_valid; after release ready=1 and op_count=0.
- Stub dp_done to rise exactly on WAIT cycle 15 (TIMEOUT-1) → success path taken, result captured, timeout_err=0.
